// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer and its pattern generator.
package bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_RUN     = 3'd2,
      S_DRAIN   = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } bist_state_t;

   localparam int unsigned SIG_W        = 8;
   // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci LFSR: bits 7,5,4,3.
   localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
   localparam logic [7:0]  DEFAULT_SEED = 8'h01;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Fibonacci LFSR pattern source; load takes priority over en.
module bist_lfsr
   import bist_pkg::*;
#(
   parameter logic [7:0] RESET_VAL = DEFAULT_SEED
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   // Load (zero seed forced to the default so the LFSR never locks up), else step.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         q <= RESET_VAL;
      else if (load)
         q <= (seed == 8'h00) ? DEFAULT_SEED : seed;
      else if (en)
         q <= lfsr_next(q);
   end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: resets the MISR, streams LFSR patterns, freezes and checks the signature.
module bist_controller
   import bist_pkg::*;
#(
   parameter int unsigned N_PATTERNS   = 255,
   parameter int unsigned CNT_W        = 16,
   parameter logic [7:0]  LFSR_SEED    = 8'h01,
   parameter logic [7:0]  GOLDEN_SIG   = 8'h00,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             bist_start,
   input  logic [SIG_W-1:0] misr_sig,
   output logic             test_mode,
   output logic [7:0]       pattern,
   output logic             misr_rst,
   output logic             bist_end,
   output logic             busy,
   output logic             bist_done,
   output logic             bist_pass
);

   localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? DEFAULT_SEED : LFSR_SEED;
   localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(N_PATTERNS - 1);
   localparam int unsigned      DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(DRAIN_CYCLES - 1);

   bist_state_t      state;
   logic [CNT_W-1:0] pat_cnt;
   logic [DRN_W-1:0] drn_cnt;
   logic             lfsr_load;
   logic             lfsr_en;

   // LFSR control: seed on accepted start so INIT already shows the seed; the
   // step on the final RUN cycle is suppressed so DRAIN holds the last pattern.
   always_comb begin
      lfsr_load = bist_start && ((state == S_IDLE) || (state == S_DONE));
      lfsr_en   = (state == S_RUN) && (pat_cnt != LAST_PAT);
   end

   bist_lfsr #(
      .RESET_VAL (SEED_EFF)
   ) u_lfsr (
      .CLK  (CLK),
      .RST  (RST),
      .load (lfsr_load),
      .en   (lfsr_en),
      .seed (SEED_EFF),
      .q    (pattern)
   );

   // Sequencer FSM; every output is registered with the value of the state being entered.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         test_mode <= 1'b0;
         misr_rst  <= 1'b1;
         bist_end  <= 1'b1;
         busy      <= 1'b0;
         bist_done <= 1'b0;
         bist_pass <= 1'b0;
         pat_cnt   <= '0;
         drn_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bist_start) begin
                  state     <= S_INIT;
                  misr_rst  <= 1'b1;
                  bist_end  <= 1'b1;
                  test_mode <= 1'b1;
                  busy      <= 1'b1;
                  bist_done <= 1'b0;
                  bist_pass <= 1'b0;
                  pat_cnt   <= '0;
               end
            end
            S_INIT: begin
               state    <= S_RUN;
               misr_rst <= 1'b0;
               bist_end <= 1'b0;
            end
            S_RUN: begin
               pat_cnt <= pat_cnt + CNT_W'(1);
               if (pat_cnt == LAST_PAT) begin
                  state     <= S_DRAIN;
                  bist_end  <= 1'b1;
                  test_mode <= 1'b0;
                  drn_cnt   <= '0;
               end
            end
            S_DRAIN: begin
               if (drn_cnt == LAST_DRN)
                  state <= S_COMPARE;
               else
                  drn_cnt <= drn_cnt + DRN_W'(1);
            end
            S_COMPARE: begin
               state     <= S_DONE;
               bist_pass <= (misr_sig == GOLDEN_SIG);
               bist_done <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench: two controller instances (seeded and zero-seed) against a reference model.
module tb_bist_controller;

   localparam int unsigned NP   [2] = '{4, 5};
   localparam logic [7:0]  SEED [2] = '{8'h01, 8'h00};
   localparam logic [7:0]  GOLD [2] = '{8'hA5, 8'h00};
   localparam int unsigned DRAIN    = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       start   [2];
   logic [7:0] sig_in  [2];
   logic       tm      [2];
   logic [7:0] pat     [2];
   logic       mrst    [2];
   logic       bend    [2];
   logic       bsy     [2];
   logic       done    [2];
   logic       pass    [2];

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 CLK = ~CLK;

   bist_controller #(
      .N_PATTERNS   (4),
      .CNT_W        (16),
      .LFSR_SEED    (8'h01),
      .GOLDEN_SIG   (8'hA5),
      .DRAIN_CYCLES (2)
   ) dut_a (
      .CLK (CLK), .RST (RST), .bist_start (start[0]), .misr_sig (sig_in[0]),
      .test_mode (tm[0]), .pattern (pat[0]), .misr_rst (mrst[0]), .bist_end (bend[0]),
      .busy (bsy[0]), .bist_done (done[0]), .bist_pass (pass[0])
   );

   bist_controller #(
      .N_PATTERNS   (5),
      .CNT_W        (16),
      .LFSR_SEED    (8'h00),
      .GOLDEN_SIG   (8'h00),
      .DRAIN_CYCLES (2)
   ) dut_b (
      .CLK (CLK), .RST (RST), .bist_start (start[1]), .misr_sig (sig_in[1]),
      .test_mode (tm[1]), .pattern (pat[1]), .misr_rst (mrst[1]), .bist_end (bend[1]),
      .busy (bsy[1]), .bist_done (done[1]), .bist_pass (pass[1])
   );

   // Reference: k-th pattern of the polynomial sequence from the (nonzero-forced) seed.
   function automatic logic [7:0] model_pat(input logic [7:0] seed, input int unsigned k);
      logic [7:0] s;
      s = (seed == 8'h00) ? 8'h01 : seed;
      for (int unsigned i = 0; i < k; i++)
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One complete start-to-done run; glitch (<0 = none) pulses bist_start during that RUN cycle.
   task automatic run(input int unsigned d, input logic [7:0] sig, input int glitch);
      sig_in[d] = sig;
      start[d]  = 1'b1;
      tick();
      start[d]  = 1'b0;
      chk("init_misr_rst", {31'd0, mrst[d]}, 1);
      chk("init_busy",     {31'd0, bsy[d]},  1);
      chk("init_done",     {31'd0, done[d]}, 0);
      chk("init_pass",     {31'd0, pass[d]}, 0);
      chk("init_tm",       {31'd0, tm[d]},   1);
      for (int k = 0; k < int'(NP[d]); k++) begin
         tick();
         start[d] = (k == glitch);
         chk("run_pattern",  {24'd0, pat[d]},  {24'd0, model_pat(SEED[d], k)});
         chk("run_bist_end", {31'd0, bend[d]}, 0);
         chk("run_misr_rst", {31'd0, mrst[d]}, 0);
         chk("run_tm",       {31'd0, tm[d]},   1);
         chk("run_busy",     {31'd0, bsy[d]},  1);
      end
      for (int unsigned i = 0; i < DRAIN; i++) begin
         tick();
         start[d] = 1'b0;
         chk("drain_bist_end", {31'd0, bend[d]}, 1);
         chk("drain_tm",       {31'd0, tm[d]},   0);
         chk("drain_pattern",  {24'd0, pat[d]},  {24'd0, model_pat(SEED[d], NP[d] - 1)});
         chk("drain_done",     {31'd0, done[d]}, 0);
      end
      tick();
      chk("cmp_busy", {31'd0, bsy[d]},  1);
      chk("cmp_done", {31'd0, done[d]}, 0);
      tick();
      chk("done_flag",     {31'd0, done[d]}, 1);
      chk("done_pass",     {31'd0, pass[d]}, {31'd0, sig == GOLD[d]});
      chk("done_busy",     {31'd0, bsy[d]},  0);
      chk("done_bist_end", {31'd0, bend[d]}, 1);
   endtask

   initial begin
      logic [7:0] rs;
      start[0] = 1'b0; start[1] = 1'b0;
      sig_in[0] = 8'h00; sig_in[1] = 8'h00;

      // reset state
      tick(); tick();
      chk("rst_tm",       {31'd0, tm[0]},   0);
      chk("rst_pattern",  {24'd0, pat[0]},  32'h01);
      chk("rst_misr_rst", {31'd0, mrst[0]}, 1);
      chk("rst_bist_end", {31'd0, bend[0]}, 1);
      chk("rst_busy",     {31'd0, bsy[0]},  0);
      chk("rst_done",     {31'd0, done[0]}, 0);
      chk("rst_pass",     {31'd0, pass[0]}, 0);
      chk("rst_b_pattern",{24'd0, pat[1]},  32'h01);
      RST = 1'b0;
      tick();

      // golden match with a start pulse during RUN, then immediate restart from DONE with a mismatch
      run(0, 8'hA5, int'($urandom_range(0, NP[0] - 1)));
      run(0, 8'hA4, -1);
      run(0, 8'hA5, -1);

      // asynchronous reset on the third RUN cycle, with bist_start asserted under reset
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_pattern", {24'd0, pat[0]}, {24'd0, model_pat(SEED[0], 2)});
      #2 RST = 1'b1;
      #1;
      chk("async_busy",     {31'd0, bsy[0]},  0);
      chk("async_misr_rst", {31'd0, mrst[0]}, 1);
      chk("async_bist_end", {31'd0, bend[0]}, 1);
      chk("async_pattern",  {24'd0, pat[0]},  32'h01);
      chk("async_tm",       {31'd0, tm[0]},   0);
      start[0] = 1'b1;
      tick();
      chk("rst_wins_busy", {31'd0, bsy[0]}, 0);
      start[0] = 1'b0;
      RST = 1'b0;
      tick();
      chk("idle_after_rst", {31'd0, bsy[0]}, 0);
      run(0, 8'hA5, -1);

      // randomized signatures and glitch positions
      for (int unsigned r = 0; r < 6; r++) begin
         rs = 8'($urandom);
         if (r[0]) rs = GOLD[0];
         run(0, rs, int'($urandom_range(0, NP[0] + 1)));
      end

      // zero seed forced to 01, five patterns
      run(1, 8'h00, -1);
      rs = 8'($urandom_range(1, 255));
      run(1, rs, int'($urandom_range(0, NP[1] - 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
